// File: rtl/regfile_hilo.sv
// Architectural GPR file (32 x DATA_WIDTH, $0 hardwired) plus HI/LO pair, 2R1W + HI/LO port.
// Reads are combinational with optional same-cycle write forwarding; no backpressure, every enabled write commits.
`timescale 1ns/1ps
module regfile_hilo #(
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 32,
    parameter int BYPASS     = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wen,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]    wd,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    output logic [DATA_WIDTH-1:0]    rd1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [DATA_WIDTH-1:0]    rd2,
    input  logic                     wen_h,
    input  logic                     wen_l,
    input  logic [DATA_WIDTH-1:0]    wd_h,
    input  logic [DATA_WIDTH-1:0]    wd_l,
    output logic [DATA_WIDTH-1:0]    hi,
    output logic [DATA_WIDTH-1:0]    lo
);
    localparam int AW = $clog2(NREG);

    // Entry 0 has no storage; it always reads as zero.
    logic [DATA_WIDTH-1:0] regs [1:NREG-1];
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;

    logic fwd_en;
    logic fwd_h;
    logic fwd_l;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (wen && (waddr != '0)) begin
                regs[waddr] <= wd;
            end
            if (wen_h) begin
                hi_q <= wd_h;
            end
            if (wen_l) begin
                lo_q <= wd_l;
            end
        end
    end

    // Forwarding is gated by reset so outputs read zero while resetn is low.
    always_comb begin
        fwd_en = (BYPASS != 0) && resetn && wen;
        fwd_h  = (BYPASS != 0) && resetn && wen_h;
        fwd_l  = (BYPASS != 0) && resetn && wen_l;
    end

    always_comb begin
        rd1 = '0;
        if (raddr1 != '0) begin
            if (fwd_en && (waddr == raddr1)) begin
                rd1 = wd;
            end else begin
                rd1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (raddr2 != '0) begin
            if (fwd_en && (waddr == raddr2)) begin
                rd2 = wd;
            end else begin
                rd2 = regs[raddr2];
            end
        end
    end

    always_comb begin
        hi = fwd_h ? wd_h : hi_q;
        lo = fwd_l ? wd_l : lo_q;
    end

    logic unused_aw;
    assign unused_aw = (AW > 0);

endmodule
